fifo_access_sched: RTL

FIFO_ACCESS_SCHED -- requirements
Module: fifo_access_sched

---
 rtl/fifo_access_sched.sv | 130 +++++++++++++
 1 files changed

// File: rtl/fifo_access_sched.sv
// Single-port FIFO scheduler: watermark FILL/DRAIN control, round-robin
// write/read strobes and an active-low four-digit scan.
module fifo_access_sched #(
    parameter int RD_PERIOD = 10,
    parameter int SCAN_DIV  = 4,
    parameter int HI_WM     = 12,
    parameter int LO_WM     = 4
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       ENwrk,
    input  logic       ENgen,
    input  logic       ENraf,
    input  logic [3:0] usedw,
    input  logic       full,
    input  logic       empty,
    output logic       wrreq,
    output logic       rdreq,
    output logic [4:1] dig,
    output logic [1:0] dsel,
    output logic [1:0] state
);

    localparam int TW = (RD_PERIOD > 1) ? $clog2(RD_PERIOD) : 1;
    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [TW-1:0] TMR_MAX = TW'(RD_PERIOD - 1);
    localparam logic [PW-1:0] PSC_MAX = PW'(SCAN_DIV - 1);
    localparam logic [3:0] HI = 4'(HI_WM);
    localparam logic [3:0] LO = 4'(LO_WM);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [TW-1:0] tmr_q, tmr_d;
    logic [PW-1:0] psc_q, psc_d;
    logic [1:0]    dsel_q, dsel_d;
    logic [3:0]    dig_q, dig_d;
    logic          rd_pend_q, rd_pend_d;
    logic          last_rd_q, last_rd_d;
    logic          wrreq_q, wrreq_d;
    logic          rdreq_q, rdreq_d;
    logic          active, tmr_wrap, scan_adv;
    logic          wr_elig, rd_elig;

    always_comb begin
        state_d = state_q;
        if (!ENwrk) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:  state_d = FILL;
                FILL:  if (usedw >= HI || full) state_d = DRAIN;
                DRAIN: if (usedw <= LO && !full) state_d = FILL;
                default: state_d = IDLE;
            endcase
        end
    end

    // Read timer only runs while a transfer state is live and reads are enabled.
    always_comb begin
        active   = ENwrk && (state_q == FILL || state_q == DRAIN);
        tmr_wrap = active && ENraf && (tmr_q == TMR_MAX);
        tmr_d    = tmr_q;
        if (!active) begin
            tmr_d = '0;
        end else if (ENraf) begin
            tmr_d = tmr_wrap ? '0 : tmr_q + 1'b1;
        end
    end

    always_comb begin
        wr_elig   = ENwrk && (state_q == FILL) && ENgen && !full;
        rd_elig   = ENwrk && rd_pend_q && !empty;
        // On a tie the side that lost last time wins.
        wrreq_d   = wr_elig && (!rd_elig || last_rd_q);
        rdreq_d   = rd_elig && (!wr_elig || !last_rd_q);
        last_rd_d = last_rd_q;
        if (rdreq_d) begin
            last_rd_d = 1'b1;
        end else if (wrreq_d) begin
            last_rd_d = 1'b0;
        end
        rd_pend_d = active && (tmr_wrap || (rd_pend_q && !rdreq_d));
    end

    always_comb begin
        scan_adv = ENwrk && (psc_q == PSC_MAX);
        psc_d    = psc_q;
        if (ENwrk) begin
            psc_d = scan_adv ? '0 : psc_q + 1'b1;
        end
        dsel_d = scan_adv ? dsel_q + 2'd1 : dsel_q;
        dig_d  = ENwrk ? ~(4'b0001 << dsel_d) : 4'b1111;
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q   <= IDLE;
            tmr_q     <= '0;
            psc_q     <= '0;
            dsel_q    <= 2'd0;
            dig_q     <= 4'b1111;
            rd_pend_q <= 1'b0;
            last_rd_q <= 1'b1;
            wrreq_q   <= 1'b0;
            rdreq_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            tmr_q     <= tmr_d;
            psc_q     <= psc_d;
            dsel_q    <= dsel_d;
            dig_q     <= dig_d;
            rd_pend_q <= rd_pend_d;
            last_rd_q <= last_rd_d;
            wrreq_q   <= wrreq_d;
            rdreq_q   <= rdreq_d;
        end
    end

    assign wrreq = wrreq_q;
    assign rdreq = rdreq_q;
    assign dig   = dig_q;
    assign dsel  = dsel_q;
    assign state = state_q;

endmodule
